// File: rtl/dualport_ram_sync.sv
`default_nettype none
// ============================================================================
//  Module      : dualport_ram_sync
//  Description : Single-clock simple dual-port RAM with one write port and one
//                read port. The read is synchronous and registered. Writes
//                have per-lane enables. Same-address read-during-write returns
//                either the old word or the merged new word. An optional
//                output register adds a second stage of read latency. An
//                optional post-reset sequencer zeroes every word.
//  Ports       : clk        sole clock, posedge
//                rst        synchronous reset, active-high
//                w_en       write request
//                w_addr     write address
//                w_data     write data
//                w_be       per-lane write enables
//                r_en       read request
//                r_addr     read address
//                r_data     read data, holds until the next read completes
//                r_valid    one-cycle pulse when r_data carries a read result
//                init_busy  clear sequence running, requests are dropped
//  Revision    : 1.0  initial release
// ============================================================================
module dualport_ram_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int CLEAR_INIT = 1,
    localparam int NLANES    = DATA_WIDTH / LANE_WIDTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [AW-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [NLANES-1:0]     w_be,
    input  logic                  r_en,
    input  logic [AW-1:0]         r_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  init_busy
);

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [AW-1:0]         r_clr_addr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    logic                  w_ready;
    logic                  w_wr_act;
    logic                  w_rd_act;
    logic                  w_mem_we;
    logic [AW-1:0]         w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic [NLANES-1:0]     w_mem_be;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // ------------------------------------------------------------------------
    // Clear sequencer. Reset restarts the sweep from address 0. The memory
    // array itself is not reset; the sweep is what zeroes it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_READY;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_last_addr) begin
                        r_state <= ST_READY;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                end
            endcase
        end
    end

    // The busy flag covers the reset cycles as well, so a requester sees no
    // gap between reset and the start of the sweep.
    assign init_busy = (CLEAR_INIT != 0) && (rst || (r_state == ST_CLEAR));

    // User requests are accepted only in READY and never on a reset edge.
    assign w_ready  = !rst && (r_state == ST_READY);
    assign w_wr_act = w_en && w_ready;
    assign w_rd_act = r_en && w_ready;

    // ------------------------------------------------------------------------
    // Write port mux: the sweep owns the port while clearing.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = w_addr;
        w_mem_data = w_data;
        w_mem_be   = w_be;
        if (!rst && (r_state == ST_CLEAR)) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_addr;
            w_mem_data = '0;
            w_mem_be   = '1;
        end else if (w_wr_act) begin
            w_mem_we   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NLANES; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                        w_mem_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read word. The array read sees the pre-write contents because the write
    // above is non-blocking. In new-data mode the enabled lanes of a
    // colliding write are forwarded over the stored word.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_word = r_mem[r_addr];
        if ((RDW_MODE != 0) && w_wr_act && (w_addr == r_addr)) begin
            for (int i = 0; i < NLANES; i++) begin
                if (w_be[i]) begin
                    w_rd_word[i*LANE_WIDTH +: LANE_WIDTH] =
                        w_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // First read stage: data only updates on an accepted read so the output
    // holds its last value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_act;
            if (w_rd_act) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_out_valid;
            logic [DATA_WIDTH-1:0] r_out_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end else begin
                    r_out_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_out_data <= r_s1_data;
                    end
                end
            end

            assign r_data  = r_out_data;
            assign r_valid = r_out_valid;
        end else begin : g_no_out_reg
            assign r_data  = r_s1_data;
            assign r_valid = r_s1_valid;
        end
    endgenerate

endmodule
`default_nettype wire
